stopwatch_ctrl: RTL
===================

# stopwatch_ctrl

Front-end control stage for the stopwatch, placed directly upstream of the BCD counter / seven-segment chain. It synchronises and debounces two raw push-buttons and runs a start/pause/clear state machine. It also divides the board clock into a one-cycle tenth-of-second `Tick`. The downstream counters consume `Run`, `Tick` and `Clear` instead of a free-running clock and a raw `Start` level.

## Interface
- `TICK_DIV`, default 5000000: `Clk` cycles per `Tick` (50 MHz → 10 Hz); legal range ≥ 2.
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles needed to accept a button change (20 ms at 50 MHz); legal range ≥ 1.
- `Clk`  in  1  single system clock; all logic is on the rising edge.
- `nReset`  in  1  asynchronous, active-low reset.
- `BtnStartStop`  in  1  raw, asynchronous, active-high start/pause button.
- `BtnClear`  in  1  raw, asynchronous, active-high clear button.
- `Run`  out  1  high while the state is RUN.
- `Tick`  out  1  one-cycle pulse every `TICK_DIV` cycles while running.
- `Clear`  out  1  one-cycle pulse; downstream counters clear synchronously to zero.
- `State`  out  2  current state: 00 IDLE, 01 RUN, 10 PAUSE. The value 11 is never produced.

## Operation
- **Reset:** `nReset` low clears the following immediately, regardless of `Clk`:
  - synchronisers, debounce counters, stable levels and prescaler go to 0;
  - state goes to IDLE;
  - `Run`, `Tick`, `Clear` go to 0 and `State` goes to 00.
- **Synchroniser:** each button passes through a 2-flop synchroniser before any other use.
- **Debounce (per button):**
  - The counter increments while the synchronised level differs from the stable level.
  - It resets to 0 on any cycle where they match.
  - When the counter reaches `DEBOUNCE_CYCLES`, the stable level takes the new value and the counter resets.
- **Press event:** a registered one-cycle pulse on each 0→1 change of the stable level. Releases generate no event.
- **FSM transitions:**
  - IDLE: start press → RUN. Clear press → `Clear` pulse, stay in IDLE.
  - RUN: start press → PAUSE. Clear press is ignored.
  - PAUSE: start press → RUN. Clear press → IDLE with a `Clear` pulse.
- **Simultaneous events (same cycle):**
  - IDLE: → RUN and `Clear` pulses.
  - RUN: → PAUSE; the clear press is dropped.
  - PAUSE: clear wins → IDLE with `Clear`; the start press is dropped.
- **Prescaler:** width is clog2(`TICK_DIV`).
  - It advances only while the state register is RUN.
  - At `TICK_DIV`-1 it wraps to 0 and `Tick` is registered high for one cycle.
  - It holds its value in PAUSE, so a partial tenth is preserved.
  - It is forced to 0 on any edge that issues `Clear`.
- **RUN→PAUSE on a terminal count:** the prescaler still advances on the edge where the press event is seen, so a terminal count on that edge still emits `Tick`.
- **Outputs:** all outputs are registered. `Run` and `State` are decoded from the state register.

## Timing
- **Button latency:** a raw press held steady reaches the state register, and therefore `Run`/`State`, at Clk edge `DEBOUNCE_CYCLES`+4 after first sampling:
  - 2 edges of synchroniser;
  - `DEBOUNCE_CYCLES` edges of debounce;
  - 1 edge for the event;
  - 1 edge for the state update.
- Button glitches shorter than `DEBOUNCE_CYCLES` cycles produce no event.
- A press held indefinitely produces exactly one event.
- `Clear` goes high on the same edge as the state update that issues it, for exactly one cycle.
- **Tick timing:** if `Run` rises at edge E with the prescaler at 0, `Tick` is high after edges E+`TICK_DIV`, E+2·`TICK_DIV`, and so on.
- `Tick` is never high in two consecutive cycles.
- `Tick` is never high while the state register is IDLE or PAUSE, except on the one-cycle overlap described for RUN→PAUSE.
- **Reset mid-operation:** asserting `nReset` at any point returns all outputs to 0 and the state to IDLE within the same cycle. The first press after release needs the full latency.

## Test plan
Parameters for all scenarios: `TICK_DIV`=10, `DEBOUNCE_CYCLES`=4.

1. **Reset/idle:** hold `nReset` low for 3 cycles, then release with buttons low → `Run`=0, `Tick`=0, `Clear`=0, `State`=00 for 50 cycles.
2. **Start and tick:** `BtnStartStop` high for 20 cycles → `Run` rises 8 edges after first sampling. `Tick` then pulses every 10 cycles: 5 pulses in 50 cycles, each 1 cycle wide.
3. **Bounce rejection:** toggle `BtnStartStop` with high/low widths of 3 cycles for 30 cycles → `State` stays 00. Holding it high for 5 cycles afterwards → exactly one transition to RUN.
4. **Pause preserves phase:** run until the prescaler reaches 6, press start → PAUSE, no `Tick` for 100 cycles. Press start again → first `Tick` 4 cycles after `Run` re-asserts.
5. **Clear paths:**
   - Clear in RUN → ignored, no `Clear` pulse.
   - Clear in PAUSE → `State`=00 and a single 1-cycle `Clear`.
   - Next start → first `Tick` a full 10 cycles after `Run`.
6. **Simultaneous events and mid-run reset:**
   - Both buttons pressed together in PAUSE → IDLE plus `Clear`.
   - Both pressed together in IDLE → RUN plus `Clear`.
   - Pull `nReset` low for 1 cycle while running → all outputs 0 and `State`=00 immediately.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
// Front-end control stage for the stopwatch. It synchronises and debounces
// the two raw push-buttons and turns their presses into one-cycle events.
// A start/pause/clear state machine consumes those events. While running,
// the board clock is divided into a one-cycle tenth-of-second Tick.
//
// Parameters
//   TICK_DIV         Clk cycles per Tick (>= 2)
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a change (>= 1)
//
// Ports
//   Clk           in   system clock, rising edge
//   nReset        in   asynchronous active-low reset
//   BtnStartStop  in   raw start/pause button, active high
//   BtnClear      in   raw clear button, active high
//   Run           out  high while the state is RUN
//   Tick          out  one-cycle pulse every TICK_DIV cycles while running
//   Clear         out  one-cycle pulse that clears the downstream counters
//   State         out  00 IDLE, 01 RUN, 10 PAUSE
module stopwatch_ctrl #(
  parameter int TICK_DIV        = 5000000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       Clk,
  input  logic       nReset,
  input  logic       BtnStartStop,
  input  logic       BtnClear,
  output logic       Run,
  output logic       Tick,
  output logic       Clear,
  output logic [1:0] State
);

  localparam int PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } stateT;

  // Bit 0 carries the start/pause button, bit 1 the clear button.
  logic [1:0] btnRaw;
  logic [1:0] syncMeta;
  logic [1:0] syncOut;
  logic [1:0] stableLvl;
  logic [1:0] stablePrev;
  logic [1:0] pressEv;
  logic [DB_W-1:0] dbCnt [2];

  logic startEv;
  logic clearEv;

  stateT state;
  stateT stateNext;
  logic  clearNext;

  logic [PRESC_W-1:0] presc;

  assign btnRaw  = {BtnClear, BtnStartStop};
  assign startEv = pressEv[0];
  assign clearEv = pressEv[1];

  // Two-flop synchroniser; nothing downstream ever looks at the raw pins.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      syncMeta <= '0;
      syncOut  <= '0;
    end else begin
      syncMeta <= btnRaw;
      syncOut  <= syncMeta;
    end
  end

  // Debounce: count consecutive cycles where the synchronised level
  // disagrees with the accepted level. The counter tops out at
  // DEBOUNCE_CYCLES-1 because the edge that would reach DEBOUNCE_CYCLES
  // is the one that adopts the new level. Any agreeing cycle restarts it,
  // so short glitches never get through.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      stableLvl <= '0;
      for (int i = 0; i < 2; i++) begin
        dbCnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (syncOut[i] != stableLvl[i]) begin
          if (dbCnt[i] == DB_LAST) begin
            stableLvl[i] <= syncOut[i];
            dbCnt[i]     <= '0;
          end else begin
            dbCnt[i] <= dbCnt[i] + DB_W'(1);
          end
        end else begin
          dbCnt[i] <= '0;
        end
      end
    end
  end

  // Press events: a registered pulse on each rising edge of the accepted
  // level. Releases are deliberately silent.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      stablePrev <= '0;
      pressEv    <= '0;
    end else begin
      stablePrev <= stableLvl;
      pressEv    <= stableLvl & ~stablePrev;
    end
  end

  // State register and the registered Clear pulse.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state <= IDLE;
      Clear <= 1'b0;
    end else begin
      state <= stateNext;
      Clear <= clearNext;
    end
  end

  // Next-state logic. When both presses land together, IDLE honours both.
  // RUN drops the clear, and PAUSE lets the clear win over the start.
  always_comb begin
    stateNext = state;
    clearNext = 1'b0;
    case (state)
      IDLE: begin
        if (startEv) begin
          stateNext = RUN;
        end
        if (clearEv) begin
          clearNext = 1'b1;
        end
      end
      RUN: begin
        if (startEv) begin
          stateNext = PAUSE;
        end
      end
      PAUSE: begin
        if (clearEv) begin
          stateNext = IDLE;
          clearNext = 1'b1;
        end else if (startEv) begin
          stateNext = RUN;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Prescaler: it advances whenever the state register holds RUN, including
  // the edge that moves to PAUSE. A terminal count on that edge therefore
  // still yields a Tick. The value is held in PAUSE so a partial tenth
  // survives, and any edge that issues Clear restarts it from zero.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      presc <= '0;
      Tick  <= 1'b0;
    end else if (clearNext) begin
      presc <= '0;
      Tick  <= 1'b0;
    end else if (state == RUN) begin
      if (presc == PRESC_LAST) begin
        presc <= '0;
        Tick  <= 1'b1;
      end else begin
        presc <= presc + PRESC_W'(1);
        Tick  <= 1'b0;
      end
    end else begin
      Tick <= 1'b0;
    end
  end

  assign Run   = (state == RUN);
  assign State = state;

endmodule
